// File: rtl/contador_modos.sv
// -----------------------------------------------------------------------------
// contador_modos
//
// Multi-mode synchronous counter. Every rising clock edge it either clears,
// holds, counts up by 1, counts down by 1, counts up by 3, or loads a parallel
// value. RCO is a registered one-cycle pulse that is high in the same cycle
// that Q shows a wrapped value. Feeding RCO into the enb of a following stage
// cascades counters (one cycle of lag per stage).
//
// Parameters:
//   WIDTH  counter width in bits (Q and D), minimum 2
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high clear (Q=0, RCO=0)
//   enb    in   1      count enable; 0 holds Q and drives RCO low
//   modo   in   2      00 up+1, 01 down-1, 10 up+3, 11 load D
//   D      in   WIDTH  parallel load value, used only when modo=11
//   Q      out  WIDTH  registered count
//   RCO    out  1      registered wrap pulse
//
// Per-edge priority: reset > enb=0 > modo.
// -----------------------------------------------------------------------------
module contador_modos #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam logic [1:0] MODO_UP1  = 2'b00;
    localparam logic [1:0] MODO_DN1  = 2'b01;
    localparam logic [1:0] MODO_UP3  = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH:0] STEP3 = (WIDTH + 1)'(3);

    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic [WIDTH:0]   sum3;

    // Up-by-3 computed one bit wider; the extra bit is the wrap indicator.
    assign sum3 = {1'b0, Q} + STEP3;

    // Next-state for the enabled, out-of-reset case. Reset and enb are handled
    // in the register block so X on modo/D cannot reach Q while they are
    // inactive.
    always_comb begin
        q_next   = Q;
        rco_next = 1'b0;
        unique case (modo)
            MODO_UP1: begin
                q_next   = Q + 1'b1;
                rco_next = &Q;           // old Q all-ones wraps to 0
            end
            MODO_DN1: begin
                q_next   = Q - 1'b1;
                rco_next = ~|Q;          // old Q zero wraps to all-ones
            end
            MODO_UP3: begin
                q_next   = sum3[WIDTH-1:0];
                rco_next = sum3[WIDTH];
            end
            MODO_LOAD: begin
                q_next   = D;
                rco_next = 1'b0;         // a load is never a wrap
            end
            default: begin
                q_next   = Q;
                rco_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q   <= '0;
            RCO <= 1'b0;                 // a wrap pending on this edge is dropped
        end else if (!enb) begin
            RCO <= 1'b0;
        end else begin
            Q   <= q_next;
            RCO <= rco_next;
        end
    end

endmodule

// File: tb/tb_contador_modos.sv
// -----------------------------------------------------------------------------
// tb_contador_modos
//
// Directed and random stimulus for contador_modos (WIDTH=4). Each step drives
// inputs on the falling edge, pushes the expected {RCO,Q} into a queue, and
// after the next rising edge pops and compares against the outputs.
// -----------------------------------------------------------------------------
module tb_contador_modos;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    logic [WIDTH:0] exp_q[$];

    int checks;
    int errors;
    int model_cnt;

    contador_modos #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .enb   (enb),
        .modo  (modo),
        .D     (d),
        .Q     (q),
        .RCO   (rco)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step: drive on falling edge, record expectation, compare after
    // the rising edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [WIDTH-1:0] dv,
                        input logic [WIDTH-1:0] eq, input logic erco,
                        input string tag);
        logic [WIDTH:0] want;
        @(negedge clk);
        reset = r;
        enb   = e;
        modo  = m;
        d     = dv;
        exp_q.push_back({erco, eq});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed Q=%0d RCO=%0b", tag, q, rco);
        end else begin
            want = exp_q.pop_front();
            checks++;
            assert ({rco, q} === want)
            else begin
                errors++;
                $error("FAIL %s: observed Q=%0d RCO=%0b, expected Q=%0d RCO=%0b",
                       tag, q, rco, want[WIDTH-1:0], want[WIDTH]);
            end
        end
    endtask

    // Reference model step for random stimulus, in plain integer arithmetic.
    task automatic model_step(input logic r, input logic e, input logic [1:0] m,
                              input logic [WIDTH-1:0] dv,
                              output logic [WIDTH-1:0] eq, output logic erco);
        int nxt;
        erco = 1'b0;
        if (r) begin
            model_cnt = 0;
        end else if (e) begin
            case (m)
                2'd0: nxt = model_cnt + 1;
                2'd1: nxt = model_cnt - 1;
                2'd2: nxt = model_cnt + 3;
                default: nxt = int'(dv);
            endcase
            if (m != 2'd3 && (nxt > MAXV || nxt < 0)) erco = 1'b1;
            if (nxt > MAXV) nxt = nxt - (MAXV + 1);
            if (nxt < 0) nxt = nxt + (MAXV + 1);
            model_cnt = nxt;
        end
        eq = WIDTH'(model_cnt);
    endtask

    initial begin
        logic [WIDTH-1:0] eq;
        logic             erco;
        logic             r;
        logic             e;
        logic [1:0]       m;
        logic [WIDTH-1:0] dv;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enb    = 1'b1;
        modo   = 2'b00;
        d      = '0;

        // Reset for two edges while enabled in up mode
        step(1, 1, 2'b00, 4'd0, 4'd0, 0, "reset_0");
        step(1, 1, 2'b00, 4'd0, 4'd0, 0, "reset_1");
        // Release with enb=0; X on modo/D must not disturb Q
        step(0, 0, 2'bxx, 4'bxxxx, 4'd0, 0, "hold_after_reset_0");
        step(0, 0, 2'bxx, 4'bxxxx, 4'd0, 0, "hold_after_reset_1");
        step(0, 0, 2'b00, 4'd9,    4'd0, 0, "hold_after_reset_2");

        // Load 13 then count up across the wrap
        step(0, 1, 2'b11, 4'd13, 4'd13, 0, "load_13");
        step(0, 1, 2'b00, 4'd0,  4'd14, 0, "up_14");
        step(0, 1, 2'b00, 4'd0,  4'd15, 0, "up_15");
        step(0, 1, 2'b00, 4'd0,  4'd0,  1, "up_wrap_0");
        step(0, 1, 2'b00, 4'd0,  4'd1,  0, "up_1");

        // Count down through zero
        step(0, 1, 2'b11, 4'd1, 4'd1,  0, "load_1");
        step(0, 1, 2'b01, 4'd0, 4'd0,  0, "down_0");
        step(0, 1, 2'b01, 4'd0, 4'd15, 1, "down_wrap_15");
        step(0, 1, 2'b01, 4'd0, 4'd14, 0, "down_14");

        // Step by 3
        step(0, 1, 2'b11, 4'd11, 4'd11, 0, "load_11");
        step(0, 1, 2'b10, 4'd0,  4'd14, 0, "up3_14");
        step(0, 1, 2'b10, 4'd0,  4'd1,  1, "up3_wrap_1");
        step(0, 1, 2'b10, 4'd0,  4'd4,  0, "up3_4");

        // Up-by-3 carry boundary: old Q = 13 wraps, old Q = 12 does not
        step(0, 1, 2'b11, 4'd12, 4'd12, 0, "load_12");
        step(0, 1, 2'b10, 4'd0,  4'd15, 0, "up3_from12");
        step(0, 1, 2'b11, 4'd13, 4'd13, 0, "load_13b");
        step(0, 1, 2'b10, 4'd0,  4'd0,  1, "up3_from13_wrap");

        // Load all-ones, then hold with enb=0
        step(0, 1, 2'b11, 4'd15, 4'd15, 0, "load_15");
        step(0, 0, 2'b00, 4'd0,  4'd15, 0, "hold15_0");
        step(0, 0, 2'b00, 4'd0,  4'd15, 0, "hold15_1");
        step(0, 0, 2'bxx, 4'bxxxx, 4'd15, 0, "hold15_x");

        // Loading when old Q and D are all-ones is not a wrap
        step(0, 1, 2'b11, 4'd15, 4'd15, 0, "load_15_over_15");

        // Load 0 then down gives a wrap; consecutive load-0/down wraps
        step(0, 1, 2'b11, 4'd0, 4'd0,  0, "load_0");
        step(0, 1, 2'b01, 4'd0, 4'd15, 1, "down_from0_wrap");

        // Mid-operation reset on the edge that would wrap
        step(0, 1, 2'b11, 4'd14, 4'd14, 0, "load_14");
        step(0, 1, 2'b00, 4'd0,  4'd15, 0, "up_to_15");
        step(1, 1, 2'b00, 4'd0,  4'd0,  0, "reset_suppresses_wrap");
        step(0, 1, 2'b00, 4'd0,  4'd1,  0, "up_after_reset");

        // Reset with X on modo/D
        step(1, 1'bx, 2'bxx, 4'bxxxx, 4'd0, 0, "reset_with_x");

        // Random stimulus against the integer model
        model_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 4) != 0);
            m  = 2'($urandom_range(0, 3));
            dv = WIDTH'($urandom_range(0, MAXV));
            model_step(r, e, m, dv, eq, erco);
            step(r, e, m, dv, eq, erco, "random");
        end

        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
